// File: rtl/mdu_pkg.sv
// Shared opcodes, FSM encoding and default latencies for the multiply/divide unit.
package mdu_pkg;

  localparam logic [3:0] MDU_NONE  = 4'd0;
  localparam logic [3:0] MDU_MULT  = 4'd1;
  localparam logic [3:0] MDU_MULTU = 4'd2;
  localparam logic [3:0] MDU_DIV   = 4'd3;
  localparam logic [3:0] MDU_DIVU  = 4'd4;
  localparam logic [3:0] MDU_MFHI  = 4'd5;
  localparam logic [3:0] MDU_MFLO  = 4'd6;
  localparam logic [3:0] MDU_MTHI  = 4'd7;
  localparam logic [3:0] MDU_MTLO  = 4'd8;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  localparam int DEF_MULT_CYCLES = 5;
  localparam int DEF_DIV_CYCLES  = 10;

  function automatic logic is_arith_op(input logic [3:0] op);
    return (op >= MDU_MULT) && (op <= MDU_DIVU);
  endfunction

  function automatic logic is_div_op(input logic [3:0] op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

  function automatic logic is_mdu_op(input logic [3:0] op);
    return (op >= MDU_MULT) && (op <= MDU_MTLO);
  endfunction

endpackage

// File: rtl/mdu_ctrl_if.sv
// Pipeline-facing signal bundle of the MDU sequencer; master = pipeline, slave = mdu_ctrl.
interface mdu_ctrl_if;
  logic [3:0]  MDUOpE;
  logic [3:0]  MDUOpD;
  logic [31:0] RsE;
  logic [31:0] RtE;
  logic        Req;
  logic        Start;
  logic        Busy;
  logic [31:0] MDUOutE;
  logic        StallMDU;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (
    output MDUOpE, MDUOpD, RsE, RtE, Req,
    input  Start, Busy, MDUOutE, StallMDU, HI, LO
  );

  modport slave (
    input  MDUOpE, MDUOpD, RsE, RtE, Req,
    output Start, Busy, MDUOutE, StallMDU, HI, LO
  );
endinterface

// File: rtl/mdu_arith.sv
// Combinational result generator: HI/LO pair for mult/multu/div/divu plus divide-by-zero flag.
module mdu_arith
  import mdu_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  output logic [31:0] hi_n,
  output logic [31:0] lo_n,
  output logic        div_zero
);

  logic [63:0]        prod_s;
  logic [31:0]        rt_safe_s;
  logic signed [31:0] rs_sg_s;
  logic signed [31:0] rt_sg_s;
  logic signed [31:0] quot_sg_s;
  logic signed [31:0] rem_sg_s;
  logic [31:0]        quot_u_s;
  logic [31:0]        rem_u_s;

  // Divider never sees a zero divisor; the commit is suppressed separately.
  assign div_zero  = is_div_op(op) && (rt == 32'd0);
  assign rt_safe_s = (rt == 32'd0) ? 32'd1 : rt;
  assign rs_sg_s   = rs;
  assign rt_sg_s   = rt_safe_s;
  assign quot_sg_s = rs_sg_s / rt_sg_s;
  assign rem_sg_s  = rs_sg_s % rt_sg_s;
  assign quot_u_s  = rs / rt_safe_s;
  assign rem_u_s   = rs % rt_safe_s;

  // Operation select; the low 64 bits of an extended product give the exact result.
  always_comb begin
    prod_s = 64'd0;
    hi_n   = 32'd0;
    lo_n   = 32'd0;
    case (op)
      MDU_MULT: begin
        prod_s = {{32{rs[31]}}, rs} * {{32{rt[31]}}, rt};
        hi_n   = prod_s[63:32];
        lo_n   = prod_s[31:0];
      end
      MDU_MULTU: begin
        prod_s = {32'd0, rs} * {32'd0, rt};
        hi_n   = prod_s[63:32];
        lo_n   = prod_s[31:0];
      end
      MDU_DIV: begin
        if ((rs == 32'h8000_0000) && (rt == 32'hFFFF_FFFF)) begin
          hi_n = 32'd0;
          lo_n = 32'h8000_0000;
        end else begin
          hi_n = rem_sg_s;
          lo_n = quot_sg_s;
        end
      end
      MDU_DIVU: begin
        hi_n = rem_u_s;
        lo_n = quot_u_s;
      end
      default: begin
        hi_n = 32'd0;
        lo_n = 32'd0;
      end
    endcase
  end

endmodule

// File: rtl/mdu_ctrl.sv
// MDU sequencer: issues mult/div, counts down the latency, owns HI/LO and D-stage stall.
// Optional build macro MDU_EXC_GUARD_EN lets Req suppress issue and mthi/mtlo writes.
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
  input logic       clk,
  input logic       reset,
  mdu_ctrl_if.slave bus
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  logic [0:0]       state_r;
  logic [CNT_W-1:0] cnt_r;
  logic             busy_r;
  logic [31:0]      hi_r;
  logic [31:0]      lo_r;
  logic [31:0]      hi_shadow_r;
  logic [31:0]      lo_shadow_r;
  logic             div_zero_r;

  logic [3:0]       op_e_s;
  logic [31:0]      hi_n_s;
  logic [31:0]      lo_n_s;
  logic             div_zero_s;
  logic             req_block_s;
  logic             start_s;
  logic [31:0]      out_e_s;

`ifdef MDU_EXC_GUARD_EN
  assign req_block_s = bus.Req;
`else
  assign req_block_s = 1'b0;
`endif

  // Reserved opcodes 9..15 behave as no-op.
  assign op_e_s  = (bus.MDUOpE > MDU_MTLO) ? MDU_NONE : bus.MDUOpE;
  assign start_s = is_arith_op(op_e_s) && !busy_r && !req_block_s;

  mdu_arith u_arith (
    .op       (op_e_s),
    .rs       (bus.RsE),
    .rt       (bus.RtE),
    .hi_n     (hi_n_s),
    .lo_n     (lo_n_s),
    .div_zero (div_zero_s)
  );

  // Sequencer state, latency counter, shadow results and architectural HI/LO.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      cnt_r       <= '0;
      busy_r      <= 1'b0;
      hi_r        <= 32'd0;
      lo_r        <= 32'd0;
      hi_shadow_r <= 32'd0;
      lo_shadow_r <= 32'd0;
      div_zero_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start_s) begin
            hi_shadow_r <= hi_n_s;
            lo_shadow_r <= lo_n_s;
            div_zero_r  <= div_zero_s;
            cnt_r       <= is_div_op(op_e_s) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
            state_r     <= BUSY;
            busy_r      <= 1'b1;
          end else if (!req_block_s && (op_e_s == MDU_MTHI)) begin
            hi_r <= bus.RsE;
          end else if (!req_block_s && (op_e_s == MDU_MTLO)) begin
            lo_r <= bus.RsE;
          end else begin
            busy_r <= 1'b0;
          end
        end
        BUSY: begin
          if (cnt_r == CNT_W'(1)) begin
            // A zero divisor burns the full latency but leaves HI/LO untouched.
            if (!div_zero_r) begin
              hi_r <= hi_shadow_r;
              lo_r <= lo_shadow_r;
            end else begin
              hi_r <= hi_r;
            end
            cnt_r   <= '0;
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end else begin
            cnt_r <= cnt_r - CNT_W'(1);
          end
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= '0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  // Move-from read port sees HI/LO as currently registered.
  always_comb begin
    out_e_s = 32'd0;
    case (op_e_s)
      MDU_MFHI: out_e_s = hi_r;
      MDU_MFLO: out_e_s = lo_r;
      default:  out_e_s = 32'd0;
    endcase
  end

  assign bus.Start    = start_s;
  assign bus.Busy     = busy_r;
  assign bus.MDUOutE  = out_e_s;
  assign bus.StallMDU = is_mdu_op(bus.MDUOpD) && (start_s || busy_r);
  assign bus.HI       = hi_r;
  assign bus.LO       = lo_r;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: vector table with scoreboard plus corner-case sequences.
module tb_mdu_ctrl;
  import mdu_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mdu_ctrl_if bus ();

  mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [3:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [3:0]  dop;
  } vec_t;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  vec_t vecs [9];
  exp_t sb_q [$];

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one arith op with dop waiting in D; dop (0/mfhi/mflo) moves into E once the op retires.
  task automatic run_op(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                        input logic [3:0] dop, input int n);
    logic [31:0] stall_exp;
    exp_t        e;
    stall_exp = (dop >= MDU_MULT && dop <= MDU_MTLO) ? 32'd1 : 32'd0;
    @(posedge clk); #1;
    bus.MDUOpE = op; bus.RsE = rs; bus.RtE = rt; bus.MDUOpD = dop;
    e.hi = exp_hi; e.lo = exp_lo;
    sb_q.push_back(e);
    @(negedge clk);
    check32("start", 32'(bus.Start), 32'd1);
    check32("stall_issue", 32'(bus.StallMDU), stall_exp);
    @(posedge clk); #1;
    bus.MDUOpE = MDU_NONE;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      check32("busy", 32'(bus.Busy), 32'd1);
      check32("stall_busy", 32'(bus.StallMDU), stall_exp);
      @(posedge clk); #1;
    end
    bus.MDUOpE = dop;
    bus.MDUOpD = MDU_NONE;
    @(negedge clk);
    check32("busy_done", 32'(bus.Busy), 32'd0);
    check32("stall_done", 32'(bus.StallMDU), 32'd0);
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard: got empty queue expected one entry");
    end else begin
      e = sb_q.pop_front();
      check32("hi", bus.HI, e.hi);
      check32("lo", bus.LO, e.lo);
      if (dop == MDU_MFHI)      check32("mfhi_after", bus.MDUOutE, e.hi);
      else if (dop == MDU_MFLO) check32("mflo_after", bus.MDUOutE, e.lo);
      else                      check32("out_none", bus.MDUOutE, 32'd0);
    end
  endtask

  // Protocol watch: no MDU opcode may reach E while an operation is counting.
  always @(negedge clk) begin
    if (reset === 1'b0 && bus.Busy === 1'b1 && bus.MDUOpE >= MDU_MULT && bus.MDUOpE <= MDU_MTLO) begin
      errors++;
      $display("FAIL op_while_busy: got op %0d expected none", bus.MDUOpE);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{MDU_MULT,  32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA, MDU_NONE};
    vecs[1] = '{MDU_MULTU, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFE, MDU_MFLO};
    vecs[2] = '{MDU_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, MDU_MFHI};
    vecs[3] = '{MDU_DIVU,  32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E, MDU_MFLO};
    vecs[4] = '{MDU_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, MDU_MFHI};
    vecs[5] = '{MDU_MULT,  32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, MDU_NONE};
    vecs[6] = '{MDU_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, MDU_MFLO};
    vecs[7] = '{MDU_MULTU, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, MDU_MFHI};
    vecs[8] = '{MDU_DIVU,  32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32'h0FFF_FFFF, MDU_NONE};

    reset = 1'b1;
    bus.MDUOpE = MDU_NONE; bus.MDUOpD = MDU_NONE;
    bus.RsE = 32'd0; bus.RtE = 32'd0; bus.Req = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check32("rst_hi", bus.HI, 32'd0);
    check32("rst_lo", bus.LO, 32'd0);
    check32("rst_busy", 32'(bus.Busy), 32'd0);
    check32("rst_start", 32'(bus.Start), 32'd0);

    // Reserved opcode behaves as none in both E and D.
    @(posedge clk); #1;
    bus.MDUOpE = 4'd12; bus.MDUOpD = 4'd12;
    @(negedge clk);
    check32("rsvd_start", 32'(bus.Start), 32'd0);
    check32("rsvd_out", bus.MDUOutE, 32'd0);
    check32("rsvd_stall", 32'(bus.StallMDU), 32'd0);
    @(posedge clk); #1;
    bus.MDUOpE = MDU_NONE; bus.MDUOpD = MDU_NONE;
    @(negedge clk);
    check32("rsvd_busy", 32'(bus.Busy), 32'd0);

    for (int i = 0; i < 9; i++)
      run_op(vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].hi, vecs[i].lo, vecs[i].dop,
             is_div_op(vecs[i].op) ? 10 : 5);

    // mthi/mtlo take effect at the next edge, then divide by zero keeps them.
    @(posedge clk); #1;
    bus.MDUOpE = MDU_MTHI; bus.RsE = 32'h0000_1234;
    @(negedge clk);
    check32("mthi_start", 32'(bus.Start), 32'd0);
    @(posedge clk); #1;
    bus.MDUOpE = MDU_MTLO; bus.RsE = 32'h0000_5678;
    @(negedge clk);
    check32("mthi_hi", bus.HI, 32'h0000_1234);
    check32("mthi_busy", 32'(bus.Busy), 32'd0);
    @(posedge clk); #1;
    bus.MDUOpE = MDU_MFHI;
    @(negedge clk);
    check32("mfhi", bus.MDUOutE, 32'h0000_1234);
    check32("mtlo_lo", bus.LO, 32'h0000_5678);
    @(posedge clk); #1;
    bus.MDUOpE = MDU_MFLO;
    @(negedge clk);
    check32("mflo", bus.MDUOutE, 32'h0000_5678);
    run_op(MDU_DIVU, 32'd5, 32'd0, 32'h0000_1234, 32'h0000_5678, MDU_NONE, 10);

    // Reset in busy cycle 3 of a div aborts it.
    @(posedge clk); #1;
    bus.MDUOpE = MDU_DIV; bus.RsE = 32'd100; bus.RtE = 32'd3;
    @(negedge clk);
    check32("abort_start", 32'(bus.Start), 32'd1);
    @(posedge clk); #1 bus.MDUOpE = MDU_NONE;
    @(posedge clk); #1;
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    check32("abort_busy3", 32'(bus.Busy), 32'd1);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check32("abort_busy", 32'(bus.Busy), 32'd0);
    check32("abort_hi", bus.HI, 32'd0);
    check32("abort_lo", bus.LO, 32'd0);
    @(posedge clk); #1 bus.MDUOpE = MDU_MFLO;
    @(negedge clk);
    check32("abort_mflo", bus.MDUOutE, 32'd0);
    repeat (10) @(posedge clk);
    #1 bus.MDUOpE = MDU_NONE;
    @(negedge clk);
    check32("abort_lo_late", bus.LO, 32'd0);

`ifdef MDU_EXC_GUARD_EN
    // Req suppresses issue and move-to writes.
    @(posedge clk); #1;
    bus.MDUOpE = MDU_MULT; bus.RsE = 32'd3; bus.RtE = 32'd3; bus.Req = 1'b1;
    @(negedge clk);
    check32("req_start", 32'(bus.Start), 32'd0);
    @(posedge clk); #1;
    bus.MDUOpE = MDU_MTHI; bus.RsE = 32'h0000_DEAD;
    @(negedge clk);
    check32("req_busy", 32'(bus.Busy), 32'd0);
    @(posedge clk); #1;
    bus.MDUOpE = MDU_NONE; bus.Req = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    check32("req_hi", bus.HI, 32'd0);
    check32("req_lo", bus.LO, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mdu_ctrl.md
# mdu_ctrl

Sequencer for the multiply/divide unit in the 5-stage MIPS pipeline. It accepts the 4-bit MDU opcode carried into the E stage, runs multi-cycle mult/multu/div/divu with a down-counter, owns the HI/LO registers, serves mfhi/mflo/mthi/mtlo, and raises the D-stage stall while an MDU operation is issuing or in flight.

## Interface
Parameters:
- MULT_CYCLES, 5: busy cycles for mult/multu.
- DIV_CYCLES, 10: busy cycles for div/divu.

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
- clk, input, 1: sole clock; all state updates on the rising edge.
- reset, input, 1: synchronous, active-high reset.
- MDUOpE, input, 4: opcode of the instruction in E. 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo; 9–15 are treated as 0.
- MDUOpD, input, 4: opcode of the instruction in D; used only for stall generation.
- RsE, input, 32: forwarded rs operand in E.
- RtE, input, 32: forwarded rt operand in E.
- Req, input, 1: exception/interrupt taken this cycle. Only honoured under MDU_EXC_GUARD_EN.
- Start, output, 1: combinational; high when a mult/multu/div/divu is accepted this cycle.
- Busy, output, 1: registered; high while an operation is counting.
- MDUOutE, output, 32: combinational; HI when MDUOpE=5, LO when MDUOpE=6, else 0.
- StallMDU, output, 1: combinational; equals (MDUOpD in 1..8) && (Start || Busy).
- HI, output, 32: architectural HI register.
- LO, output, 32: architectural LO register.

## Operation
- FSM has two states.
  - IDLE: Start = (MDUOpE in 1..4) && !Busy. On Start:
    - Compute the result pair into shadow registers hi_n/lo_n.
    - Load the counter with MULT_CYCLES or DIV_CYCLES.
    - Go to BUSY.
  - BUSY: the counter decrements each cycle. When the counter equals 1:
    - HI<=hi_n and LO<=lo_n.
    - Busy falls and the FSM returns to IDLE.
- Arithmetic:
  - mult: signed 32x32 to 64-bit; HI = upper 32 bits, LO = lower 32 bits.
  - multu: unsigned 32x32 to 64-bit; same split.
  - div/divu: LO = quotient, HI = remainder. Truncation toward zero; remainder takes the sign of the dividend.
  - div with 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0.
  - Divisor 0 (div or divu): the op still runs the full DIV_CYCLES, but HI/LO are left unchanged.
- mthi/mtlo: write RsE to HI/LO at the next edge, only when !Busy. They take effect immediately, with no busy period.
- mfhi/mflo: MDUOutE reflects HI/LO as currently registered.
- Any MDUOpE value of 1–8 while Busy is ignored. StallMDU guarantees this cannot occur; the bench asserts it never does.
- Reset:
  - HI=0, LO=0, Busy=0, counter=0, FSM=IDLE.
  - Shadow registers are cleared to 0.
  - Reset mid-operation aborts the operation; HI/LO do not receive the result.

## Timing
- Op in E during cycle t (Start=1) gives Busy=1 in cycles t+1 through t+N, and HI/LO hold the new values from cycle t+N+1.
- A mfhi entering E at t+N+1 reads the new value. StallMDU holds it in D through cycle t+N.
- Back-to-back MDU ops: the second one sits in D with StallMDU=1 until the first completes. It then issues in E at the earliest in cycle t+N+1.
- mthi/mtlo: written at the edge ending its E cycle; a mfhi in E the next cycle sees it.
- Non-MDU instructions never stall on Busy.

## Configuration
- MDU_EXC_GUARD_EN defined:
  - Req=1 suppresses Start and the mthi/mtlo write in that cycle.
  - An operation already in BUSY continues and commits (it is architecturally older).
- MDU_EXC_GUARD_EN undefined: Req is ignored and operations start unconditionally.

## Structure
- Package mdu_pkg holds:
  - localparams MDU_NONE…MDU_MTLO (values 0–8);
  - state encoding IDLE/BUSY;
  - default cycle counts.
- Sub-module mdu_arith: combinational; takes op, RsE, RtE and produces hi_n, lo_n and a div_zero flag. It is instantiated once.
- Counter width is $clog2(max(MULT_CYCLES, DIV_CYCLES)+1).

## Test plan
- mult with RsE=0xFFFFFFFE (-2), RtE=3:
  - Start=1, then Busy high for 5 cycles.
  - Then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- multu with RsE=0xFFFFFFFF, RtE=2: HI=1, LO=0xFFFFFFFE after 5 busy cycles.
- div with RsE=-7, RtE=2: after 10 cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF. A mfhi held in D shows StallMDU=1 for the duration.
- divu with RtE=0, after mthi 0x1234 and mtlo 0x5678:
  - Busy runs 10 cycles.
  - HI=0x1234, LO=0x5678 remain unchanged.
- Reset asserted in busy cycle 3 of a div:
  - Next cycle Busy=0, HI=LO=0.
  - A following mflo returns 0.
- With MDU_EXC_GUARD_EN: mult with Req=1 gives Start=0, Busy stays 0, and HI/LO are unchanged.
